// File: rtl/timer_arbiter.sv
// Shared one-shot timer granted round-robin to N_REQ requesters; delays count prescaled ticks.
// Defining TIMER_ARB_ABORT_EN adds an abort input that cuts a running delay short.
module timer_arbiter #(
    parameter int TICK_DIV = 2_000_000,
    parameter int N_REQ    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   delay,
`ifdef TIMER_ARB_ABORT_EN
    input  logic                     abort,
`endif
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int PS_W  = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [PS_W-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;

    logic               tick;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic [CNT_W-1:0]   sel_dly;
    int                 rr_j;

    assign tick = (presc_q == PS_W'(TICK_DIV - 1));

    // Scan from farthest to nearest so the nearest set bit after last_q wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        rr_j      = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            rr_j = (int'(last_q) + k) % N_REQ;
            cand = IDX_W'(rr_j);
            if (req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign sel_dly = delay[sel_idx*CNT_W +: CNT_W];

    always_comb begin
        state_d     = state_q;
        presc_d     = tick ? '0 : presc_q + PS_W'(1);
        remaining_d = remaining_q;
        last_d      = last_q;
        owner_d     = owner_q;
        grant_d     = '0;
        done_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d[sel_idx] = 1'b1;
                    owner_d          = sel_idx;
                    last_d           = sel_idx;
                    remaining_d      = sel_dly;
                    state_d          = RUN;
                end
            end
            RUN: begin
`ifdef TIMER_ARB_ABORT_EN
                if (abort) state_d = DONE;
                else
`endif
                if (remaining_q == '0) begin
                    // Zero delay: hold RUN through the grant cycle, then finish untimed.
                    if (grant_q == '0) state_d = DONE;
                end else if (tick) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_d = DONE;
                end
                if (state_d == DONE) done_d[owner_q] = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            remaining_q <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            owner_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed cycle table, round-robin/reset/abort sequences, random vs model.
module tb_timer_arbiter;
    localparam int TD = 4;
    localparam int NR = 4;
    localparam int CW = 16;
    localparam logic [63:0] D1 = 64'h0000_0000_0001_0001;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*CW-1:0] delay;
`ifdef TIMER_ARB_ABORT_EN
    logic            abort;
`endif
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;
    logic [1:0]      owner;

    int nvec = 0;
    int nerr = 0;
    int kc;
    int m_g, m_done, m_last, m_own;

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*CW-1:0] dly;
        int               n;
        logic [NR-1:0]    g;
        logic [NR-1:0]    dn;
        logic             b;
        int               own;
    } vec_t;
    localparam int NROW = 17;
    vec_t tbl [NROW];

    timer_arbiter #(.TICK_DIV(TD), .N_REQ(NR), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .delay (delay),
`ifdef TIMER_ARB_ABORT_EN
        .abort (abort),
`endif
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; tick cycles are those with kc % TD == TD-1.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) kc <= 0;
        else        kc <= kc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int want);
        nvec++;
        if (act != want) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, kc, act, want);
        end
    endtask

    function automatic int idx_of(input logic [NR-1:0] v);
        int r;
        r = 99;
        if ($countones(v) == 1)
            for (int i = 0; i < NR; i++) if (((v >> i) & 1) != 0) r = i;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        delay = '0;
`ifdef TIMER_ARB_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_g    = -10;
        m_done = -10;
        m_last = NR - 1;
        m_own  = 0;
    endtask

    // Model: one transaction at a time, described by its grant and done cycle numbers.
    task automatic chk_model();
        logic [NR-1:0] eg, ed;
        eg = (kc == m_g)    ? (NR'(1) << m_own) : '0;
        ed = (kc == m_done) ? (NR'(1) << m_own) : '0;
        chk("rnd_grant", int'(grant), int'(eg));
        chk("rnd_done",  int'(done),  int'(ed));
        chk("rnd_busy",  int'(busy),  int'(kc >= m_g && kc <= m_done));
        chk("rnd_owner", int'(owner), m_own);
    endtask

    task automatic mdl_accept();
        int d, t, idx;
        bit found;
        if (kc > m_done && req != '0) begin
            found = 1'b0;
            for (int off = 1; off <= NR; off++) begin
                idx = (m_last + off) % NR;
                if (!found && ((req >> idx) & 1) != 0) begin
                    found = 1'b1;
                    m_own = idx;
                end
            end
            m_last = m_own;
            m_g    = kc + 1;
            d      = int'(delay[m_own*CW +: CW]);
            t      = kc + 1;
            while (t % TD != TD - 1) t++;
            m_done = (d == 0) ? kc + 3 : t + TD * (d - 1) + 1;
        end
    endtask

    initial begin
        int ng, nd;
        int gidx [5];

        tbl[0]  = '{4'h1, 64'd3, 1,  4'h0, 4'h0, 1'b0, 0};
        tbl[1]  = '{4'h0, 64'd3, 1,  4'h1, 4'h0, 1'b1, 0};
        tbl[2]  = '{4'h0, 64'd3, 10, 4'h0, 4'h0, 1'b1, 0};
        tbl[3]  = '{4'h4, 64'd0, 1,  4'h0, 4'h1, 1'b1, 0};
        tbl[4]  = '{4'h4, 64'd0, 1,  4'h0, 4'h0, 1'b0, 0};
        tbl[5]  = '{4'h0, 64'd0, 1,  4'h4, 4'h0, 1'b1, 2};
        tbl[6]  = '{4'h0, 64'd0, 1,  4'h0, 4'h0, 1'b1, 2};
        tbl[7]  = '{4'h0, 64'd0, 1,  4'h0, 4'h4, 1'b1, 2};
        tbl[8]  = '{4'h1, D1,    1,  4'h0, 4'h0, 1'b0, 2};
        tbl[9]  = '{4'h3, D1,    1,  4'h1, 4'h0, 1'b1, 0};
        tbl[10] = '{4'h3, D1,    1,  4'h0, 4'h0, 1'b1, 0};
        tbl[11] = '{4'h3, D1,    1,  4'h0, 4'h1, 1'b1, 0};
        tbl[12] = '{4'h3, D1,    1,  4'h0, 4'h0, 1'b0, 0};
        tbl[13] = '{4'h0, D1,    1,  4'h2, 4'h0, 1'b1, 1};
        tbl[14] = '{4'h0, D1,    1,  4'h0, 4'h0, 1'b1, 1};
        tbl[15] = '{4'h0, D1,    1,  4'h0, 4'h2, 1'b1, 1};
        tbl[16] = '{4'h0, D1,    1,  4'h0, 4'h0, 1'b0, 1};

        // Directed table: each row's expectations hold for n cycles, then its inputs apply.
        do_reset();
        for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                chk($sformatf("tbl%0d_grant", r), int'(grant), int'(tbl[r].g));
                chk($sformatf("tbl%0d_done",  r), int'(done),  int'(tbl[r].dn));
                chk($sformatf("tbl%0d_busy",  r), int'(busy),  int'(tbl[r].b));
                chk($sformatf("tbl%0d_owner", r), int'(owner), tbl[r].own);
                req   = tbl[r].req;
                delay = tbl[r].dly;
                @(negedge clk);
            end
        end

        // All four requesting continuously: grants rotate, each after the previous done.
        do_reset();
        req   = 4'hF;
        delay = 64'h0001_0001_0001_0001;
        ng = 0;
        nd = 0;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                chk("rr_grant_after_done", nd, ng);
                gidx[ng] = idx_of(grant);
                ng++;
            end
            if (done != '0) nd++;
        end
        chk("rr_grant_count", ng, 5);
        for (int i = 0; i < ng; i++) chk($sformatf("rr_order%0d", i), gidx[i], i % NR);

        // Reset while four ticks into a nine-tick delay.
        do_reset();
        req   = 4'b0001;
        delay = 64'd9;
        @(negedge clk);
        req = '0;
        chk("rst_first_grant", int'(grant), 1);
        repeat (16) @(negedge clk);
        chk("rst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_done",  int'(done),  0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_owner", int'(owner), 0);
        req = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_hold_done", int'(done), 0);
            chk("rst_hold_busy", int'(busy), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_grant", int'(grant), 1);
        chk("rst_after_owner", int'(owner), 0);
        req = '0;

`ifdef TIMER_ARB_ABORT_EN
        // Abort with ten ticks still to go.
        do_reset();
        req   = 4'b0001;
        delay = 64'd12;
        @(negedge clk);
        req = '0;
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", int'(done), 1);
        chk("abort_busy", int'(busy), 1);
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
`endif

        // Random traffic against the transaction model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            chk_model();
            req = NR'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            for (int j = 0; j < NR; j++) delay[j*CW +: CW] = CW'($urandom_range(0, 4));
`ifdef TIMER_ARB_ABORT_EN
            abort = ($urandom_range(0, 9) == 0);
            if (abort && kc >= m_g && kc < m_done) m_done = kc + 1;
`endif
            mdl_accept();
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 2_000_000: clk cycles per timebase tick (>=2).
REQ-002 The block SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-003 The block SHALL have parameter CNT_W, default 16: delay width in ticks.
REQ-004 The block SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, N_REQ: bit i set = requester i wants the shared timer.
REQ-007 The block SHALL have port delay, input, N_REQ*CNT_W: slice [i*CNT_W +: CNT_W] = requester i delay in ticks.
REQ-008 The block SHALL have port grant, output, N_REQ: one-hot, 1-cycle pulse on acceptance.
REQ-009 The block SHALL have port done, output, N_REQ: one-hot, 1-cycle pulse on expiry.
REQ-010 The block SHALL have port busy, output, 1: timer owned (state RUN or DONE).
REQ-011 The block SHALL have port owner, output, $clog2(N_REQ): index of the current or last owner.

Function
REQ-012 Prescaler SHALL count 0..TICK_DIV-1 free-running from reset, wrap to 0, and assert internal tick for the one cycle at value TICK_DIV-1, independent of FSM state.
REQ-013 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-014 In IDLE with req != 0, SHALL select round-robin: first set bit searching upward (with wrap) from last+1, where last = previous granted index.
REQ-015 On selection, SHALL in the next cycle pulse grant[sel], set owner=sel, set last=sel, load remaining=delay slice sampled in the selection cycle, and enter RUN.
REQ-016 In RUN, each tick SHALL decrement remaining; the tick that takes remaining from 1 to 0 SHALL move FSM to DONE.
REQ-017 If the loaded delay is 0, SHALL go RUN->DONE on the next cycle without waiting for a tick.
REQ-018 In DONE, SHALL pulse done[owner] for exactly one cycle and return to IDLE the following cycle.
REQ-019 Expiry SHALL occur after exactly delay ticks counted from the first tick after grant; the partial prescaler period at grant is counted as one tick.
REQ-020 req changes while busy SHALL be ignored; requests are evaluated only in IDLE.
REQ-021 A req bit still high in IDLE after its done SHALL be treated as a new request and lose to any other pending requester.
REQ-022 At most one grant bit and one done bit SHALL ever be set; grant and done SHALL never coincide.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-024 rst_n low SHALL immediately clear prescaler, remaining, grant, done, busy, owner to 0, set last to N_REQ-1 (req 0 wins the first arbitration), and force IDLE, aborting any timing in progress without a done pulse.

Configuration
REQ-025 With macro TIMER_ARB_ABORT_EN defined, an input abort (1 bit) SHALL exist; abort high in RUN SHALL force DONE next cycle, pulsing done[owner]; abort SHALL be ignored in IDLE and DONE.
REQ-026 Without TIMER_ARB_ABORT_EN, the abort port and its logic SHALL be absent; behaviour is otherwise identical.

Verification (TICK_DIV=4, N_REQ=4, CNT_W=16)
REQ-027 Single request: req=0001, delay0=3 -> grant=0001 one cycle, busy high, done=0001 after the 3rd tick, busy low the cycle after.
REQ-028 Round-robin: req=1111 held continuously -> grants in order 0,1,2,3,0, each only after the previous done.
REQ-029 Zero delay: req=0100, delay2=0 -> grant=0100, then done=0100 two cycles later, no tick required.
REQ-030 Ignore while busy: req1 raised during RUN of req0 -> no grant until IDLE, then grant=0010.
REQ-031 Reset mid-RUN: assert rst_n low with remaining=5 -> all outputs 0 at once, no done; after release, req=1000 with req0 also high -> grant=0001 first.
REQ-032 Abort (TIMER_ARB_ABORT_EN): abort pulse in RUN with remaining=10 -> done[owner] next cycle, then IDLE.
